// File: rtl/uart_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register map,
// status word layout and transmitter state encoding.
package uart_pkg;

    localparam logic [31:0] UART_TXD_ADDR  = 32'h4000_0018;
    localparam logic [31:0] UART_STAT_ADDR = 32'h4000_001C;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 4;
    localparam int STAT_CNT_MSB = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    function automatic logic [31:0] stat_word(
        input logic       busy,
        input logic       full,
        input logic       empty,
        input logic       ovf,
        input logic [4:0] count
    );
        logic [31:0] w;
        w = '0;
        w[STAT_BUSY]                  = busy;
        w[STAT_FULL]                  = full;
        w[STAT_EMPTY]                 = empty;
        w[STAT_OVF]                   = ovf;
        w[STAT_CNT_MSB:STAT_CNT_LSB]  = count;
        return w;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous byte FIFO; a push while full is accepted only when a pop
// happens at the same edge, so the head is read before its slot is reused.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// MEM-stage mapped UART transmitter: bus decode, status readback, byte FIFO
// and an 8N1 serialiser with a registered tx line.
//
//   state | meaning
//   IDLE  | line high, pop the FIFO head when one is waiting
//   START | start bit (low) for CLK_DIV cycles
//   DATA  | eight data bits, LSB first, CLK_DIV cycles each
//   STOP  | stop bit (high) for CLK_DIV cycles
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 5208,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] Read_data,
    output logic        tx,
    output logic        tx_irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_t     state;
    logic [7:0]    shift;
    logic [2:0]    bit_idx;
    logic [15:0]   bit_cnt;
    logic          bit_done;
    logic          overflow;

    logic          push;
    logic          pop;
    logic          clr_ovf;
    logic [7:0]    fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          unused_wdata;

    assign push     = MemWrite && (Address == UART_TXD_ADDR);
    assign clr_ovf  = MemWrite && (Address == UART_STAT_ADDR) && Write_data[STAT_OVF];
    assign pop      = (state == IDLE) && !fifo_empty;
    assign bit_done = (bit_cnt == 16'(CLK_DIV - 1));
    assign unused_wdata = ^Write_data[31:8];

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (Write_data[7:0]),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign Read_data = (MemRead && (Address == UART_STAT_ADDR))
                     ? stat_word(state != IDLE, fifo_full, fifo_empty, overflow, 5'(fifo_count))
                     : 32'h0;

    // A byte is lost only when the FIFO is full and no pop frees a slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            shift   <= '0;
            bit_idx <= '0;
            bit_cnt <= '0;
            tx      <= 1'b1;
            tx_irq  <= 1'b1;
        end else begin
            tx_irq <= fifo_empty && (state == IDLE);
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    tx      <= 1'b1;
                    if (pop) begin
                        shift   <= fifo_rdata;
                        bit_idx <= '0;
                        tx      <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        tx      <= shift[0];
                        state   <= DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            tx      <= 1'b1;
                            state   <= STOP;
                        end else begin
                            // Next bit goes out straight from the pre-shift value.
                            shift   <= shift >> 1;
                            bit_idx <= bit_idx + 1'b1;
                            tx      <= shift[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (bit_done) begin
                        bit_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: directed scenarios plus random bus traffic, checked
// every cycle against a frame-schedule model of the transmitter.
module tb_uart_tx_mmio;

    localparam int CD    = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CD;
    localparam logic [31:0] TXD   = 32'h4000_0018;
    localparam logic [31:0] STAT  = 32'h4000_001C;
    localparam logic [31:0] OTHER = 32'h4000_0020;

    logic        clk;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] Read_data;
    logic        tx;
    logic        tx_irq;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: queued bytes, edge number of the last pop, the byte on the wire.
    logic [7:0] mq[$];
    int         edge_no;
    int         last_pop;
    logic [7:0] cur_byte;
    logic       ovf_m;
    logic       irq_m;

    uart_tx_mmio #(
        .CLK_DIV    (CD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Address    (Address),
        .Write_data (Write_data),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .Read_data  (Read_data),
        .tx         (tx),
        .tx_irq     (tx_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d, t=%0t)", tag, got, exp, edge_no, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        edge_no  = 0;
        last_pop = -100000;
        cur_byte = 8'h00;
        ovf_m    = 1'b0;
        irq_m    = 1'b1;
    endtask

    task automatic model_edge(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        int sz;
        bit idle_pre;
        bit popped;
        edge_no++;
        sz       = mq.size();
        idle_pre = (edge_no - 1 - last_pop) >= FRAME;
        irq_m    = (sz == 0) && idle_pre;
        popped   = idle_pre && (sz > 0);
        if (popped) begin
            cur_byte = mq.pop_front();
            last_pop = edge_no;
        end
        if (we && addr == TXD) begin
            if (sz < DEPTH || popped) mq.push_back(wd[7:0]);
            else ovf_m = 1'b1;
        end
        if (we && addr == STAT && wd[3]) ovf_m = 1'b0;
    endtask

    function automatic logic exp_tx();
        int m;
        m = edge_no - last_pop;
        if (m >= FRAME) return 1'b1;
        if (m < CD) return 1'b0;
        if (m < 9 * CD) return cur_byte[m / CD - 1];
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_stat();
        logic [31:0] w;
        w       = 32'h0;
        w[0]    = (edge_no - last_pop) < FRAME;
        w[1]    = (mq.size() == DEPTH);
        w[2]    = (mq.size() == 0);
        w[3]    = ovf_m;
        w[8:4]  = 5'(mq.size());
        return w;
    endfunction

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic rd);
        MemWrite   = we;
        Address    = addr;
        Write_data = wd;
        MemRead    = rd;
        #1;
        check_eq("read_data", Read_data, (rd && addr == STAT) ? exp_stat() : 32'h0);
        @(posedge clk);
        model_edge(we, addr, wd);
        @(negedge clk);
        check_eq("tx", {31'h0, tx}, {31'h0, exp_tx()});
        check_eq("tx_irq", {31'h0, tx_irq}, {31'h0, irq_m});
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic peek_stat(input string tag, input logic [31:0] exp);
        MemWrite = 1'b0;
        MemRead  = 1'b1;
        Address  = STAT;
        #1;
        check_eq(tag, Read_data, exp);
        MemRead  = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        reset    = 1'b0;
        MemWrite = 1'b0;
        MemRead  = 1'b1;
        Address  = STAT;
        #1;
        check_eq("rst_tx", {31'h0, tx}, 32'h1);
        check_eq("rst_irq", {31'h0, tx_irq}, 32'h1);
        check_eq("rst_stat", Read_data, 32'h4);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        MemRead = 1'b0;
        reset   = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  m_now;
        bit  found;
        logic [2:0]  sel;
        logic [31:0] addr;

        reset      = 1'b0;
        Address    = 32'h0;
        Write_data = 32'h0;
        MemWrite   = 1'b0;
        MemRead    = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("por_tx", {31'h0, tx}, 32'h1);
        reset = 1'b1;
        model_reset();

        // Idle after reset
        for (int i = 0; i < 20; i++) step(1'b0, STAT, 32'h0, 1'b1);
        peek_stat("stat_idle", 32'h0000_0004);
        check_eq("irq_idle", {31'h0, tx_irq}, 32'h1);

        // Single frame
        step(1'b1, TXD, 32'h0000_00A5, 1'b0);
        idle_steps(50);
        check_eq("irq_after_frame", {31'h0, tx_irq}, 32'h1);

        // Burst of six: one popped, four queued, one dropped
        for (int i = 0; i < 6; i++) step(1'b1, TXD, 32'h11 + i, 1'b0);
        peek_stat("stat_burst", 32'h0000_004B);

        // Write to an unmapped address leaves overflow alone; STAT write clears it
        step(1'b1, OTHER, 32'h0000_0008, 1'b0);
        peek_stat("stat_other_wr", 32'h0000_004B);
        step(1'b1, STAT, 32'h0000_0008, 1'b0);
        peek_stat("stat_ovf_clr", 32'h0000_0043);

        // Store at the pop edge with the FIFO full
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (mq.size() == DEPTH && (edge_no + 1 - last_pop) >= FRAME + 1) found = 1'b1;
            else step(1'b0, 32'h0, 32'h0, 1'b0);
        end
        check_eq("pop_edge_found", {31'h0, found}, 32'h1);
        step(1'b1, TXD, 32'h0000_0077, 1'b0);
        peek_stat("stat_push_pop", 32'h0000_0043);
        idle_steps(260);

        // Random bus traffic
        for (int i = 0; i < 3000; i++) begin
            sel = 3'($urandom_range(0, 7));
            case (sel)
                3'd0, 3'd1, 3'd2, 3'd3: addr = TXD;
                3'd4, 3'd5:             addr = STAT;
                3'd6:                   addr = OTHER;
                default:                addr = $urandom;
            endcase
            step($urandom_range(0, 7) == 0, addr, $urandom, 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of the data bits
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            m_now = edge_no - last_pop;
            if (m_now >= CD + 2 && m_now < 8 * CD) found = 1'b1;
            else step((mq.size() == 0) && (m_now >= FRAME), TXD, {24'h0, 8'($urandom)}, 1'b0);
        end
        check_eq("reach_data", {31'h0, found}, 32'h1);
        do_reset();
        step(1'b1, TXD, 32'h0000_003C, 1'b0);
        idle_steps(60);
        peek_stat("stat_end", 32'h0000_0004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
